uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receiver; counterpart to the team's uart_tx on the same serial link.
- Samples the asynchronous serial line at mid-bit and emits one byte per frame with a one-cycle valid strobe.
- Detects false starts, and flags framing errors when the stop bit reads 0.
- Sits between the board RX pin and the statistical-data command/collection logic.

Parameters:
- baud_rate, 24'd2000000, serial bit rate in bits/s.
- clock_freq, 28'd100000000, uart_clock frequency in Hz.
- Derived localparam clks_per_bit = clock_freq / baud_rate (default 50).
- Derived localparam half_bit = clks_per_bit / 2 (default 25).
- Elaboration error if clks_per_bit < 4.

Ports:
- uart_clock  input  1  system clock, all logic on rising edge.
- uart_reset  input  1  synchronous, active-high reset.
- uart_d_in  input  1  asynchronous serial RX line, idle high.
- uart_d_out  output  8  last correctly received byte; holds until the next good frame.
- uart_rx_valid  output  1  one-cycle pulse; uart_d_out is valid and new on that cycle.
- uart_frame_error  output  1  one-cycle pulse; stop bit sampled low.
- uart_rx_busy  output  1  high whenever the FSM is not in Idle.

Behaviour:
- Reset values (uart_reset high at a clock edge):
  - state = Idle; counters = 0; shift register = 0.
  - uart_d_out = 8'h00; uart_rx_valid = 0; uart_frame_error = 0; uart_rx_busy = 0.
  - Both synchronizer flops = 1, so the line reads idle.
- Reset mid-frame aborts the frame with no valid or error pulse.
- Input synchronizer: 2 flops; rx_s is the second flop. All decisions use rx_s only.
- clk_count width is 24 bits; it is cleared on every state change.
- bit_count width is 4 bits.
- States: Idle, Start, Data, Stop, Break.
- Idle:
  - If rx_s == 0, go to Start with clk_count = 0.
- Start:
  - Increment clk_count.
  - At clk_count == half_bit-1, resample rx_s.
  - If rx_s == 0, go to Data with clk_count = 0 and bit_count = 0.
  - If rx_s == 1, this is a glitch/false start: go to Idle with no pulse.
- Data:
  - At clk_count == clks_per_bit-1, sample rx_s into shift[7] and right-shift, giving LSB-first order.
  - On each sample, bit_count increments and clk_count resets.
  - After the 8th sample (bit_count reaches 8), go to Stop.
- Stop:
  - At clk_count == clks_per_bit-1, sample rx_s.
  - If rx_s == 1: on the next edge load uart_d_out with shift and pulse uart_rx_valid for exactly one cycle, then go to Idle.
  - If rx_s == 0: pulse uart_frame_error for one cycle, leave uart_d_out unchanged, then go to Break.
- Break:
  - Stay until rx_s == 1, then go to Idle.
  - This prevents a held-low line (break) from retriggering frames.
- uart_rx_valid and uart_frame_error are mutually exclusive and never high for two consecutive cycles.
- Back-to-back frames: a new start bit may begin immediately after the stop-bit sample. Idle sees it with at most 1 cycle of extra delay.
- Latency: pin falling edge to uart_rx_valid is 2 + half_bit + 9*clks_per_bit + 2 cycles, ±1. With defaults that is 479 ±1.
- Tolerance: frames whose bit period is clks_per_bit ±4% must decode correctly. This covers uart_tx's clks_per_bit+1 period.
- No backpressure: the consumer must take uart_d_out on the valid cycle. A later byte overwrites it.

Decomposition:
- Package uart_pkg:
  - Typedef uart_rx_state_t (Idle, Start, Data, Stop, Break).
  - Localparam DATA_BITS = 8.
  - Function computing clks_per_bit from clock_freq/baud_rate, shared with uart_tx.
- One sub-module, uart_rx_sync:
  - Parameterised N-flop (default 2) synchronizer with a reset value parameter (default 1).
  - Reusable for other async inputs.

Test Plan:
1. Reset with uart_d_in = 1, hold 100 cycles -> all outputs 0, uart_rx_busy = 0, no pulses.
2. Send 8'hA5 at 50 cycles/bit -> exactly one uart_rx_valid pulse at 479 ±1 cycles after the start edge, with uart_d_out = 8'hA5. Repeat for 8'h00, 8'hFF, 8'h01, 8'h80.
3. Drive uart_d_in low for 10 cycles, then high -> Start aborts to Idle, no valid/error pulse, uart_rx_busy back to 0 within 30 cycles.
4. Frame 8'h3C with stop bit = 0, line held low for 1000 cycles, then high -> one uart_frame_error pulse, uart_d_out keeps its prior value, no further pulses until the line rises. Next frame 8'h5A then decodes correctly.
5. uart_tx loopback (default params, 51-cycle bits) of three back-to-back bytes 8'h12, 8'h34, 8'h56 -> three valid pulses in order with matching data, no errors.
6. Assert uart_reset during bit 4 of a frame -> outputs return to reset values next cycle, no pulse. A following frame 8'hC3 decodes correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width and the
// bit-period helper used by both uart_rx and uart_tx.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_rx_state_t;

    // Whole clock cycles per serial bit; a zero baud rate yields 0 so the
    // caller's range check trips instead of a divide-by-zero.
    function automatic int unsigned calc_clks_per_bit(input int unsigned clk_hz,
                                                      input int unsigned baud);
        if (baud == 0) begin
            return 0;
        end
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// N-flop synchronizer for an asynchronous input; the reset value lets an
// idle-high line read as idle straight out of reset.
module uart_rx_sync #(
    parameter int   N         = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    generate
        if (N < 2) begin : g_bad_depth
            $error("uart_rx_sync: N must be at least 2");
        end
    endgenerate

    logic [N-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= {N{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[N-2:0], i_d};
        end
    end

    assign o_q = r_sync[N-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, false-start rejection, framing-error
// detection and a break state that waits for the line to return high.
module uart_rx
    import uart_pkg::*;
#(
    parameter logic [23:0] baud_rate  = 24'd2000000,
    parameter logic [27:0] clock_freq = 28'd100000000
) (
    input  logic           uart_clock,
    input  logic           uart_reset,
    input  logic           uart_d_in,
    output logic [7:0]     uart_d_out,
    output logic           uart_rx_valid,
    output logic           uart_frame_error,
    output logic           uart_rx_busy,
    output uart_rx_state_t o_dbg_state
);

    localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(32'(clock_freq), 32'(baud_rate));
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam logic [23:0] LAST_TICK    = 24'(CLKS_PER_BIT - 1);
    localparam logic [23:0] HALF_TICK    = 24'(HALF_BIT - 1);
    localparam logic [3:0]  LAST_BIT     = 4'(DATA_BITS - 1);

    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_ratio
            $error("uart_rx: clock_freq / baud_rate must be at least 4");
        end
    endgenerate

    logic w_rx_s;

    uart_rx_sync #(
        .N         (2),
        .RESET_VAL (1'b1)
    ) u_sync (
        .i_clk (uart_clock),
        .i_rst (uart_reset),
        .i_d   (uart_d_in),
        .o_q   (w_rx_s)
    );

    uart_rx_state_t r_state;
    logic [23:0]    r_clk_count;
    logic [3:0]     r_bit_count;
    logic [7:0]     r_shift;
    logic [7:0]     r_d_out;
    logic           r_valid;
    logic           r_frame_error;
    logic           r_busy;
    logic           r_load_pend;
    logic           r_err_pend;

    // The stop-bit verdict is latched into a pending flag so the FSM is
    // already back in Idle (ready for a back-to-back start bit) while the
    // result is published on the following edge.
    always_ff @(posedge uart_clock) begin
        if (uart_reset) begin
            r_state       <= ST_IDLE;
            r_clk_count   <= 24'd0;
            r_bit_count   <= 4'd0;
            r_shift       <= 8'h00;
            r_d_out       <= 8'h00;
            r_valid       <= 1'b0;
            r_frame_error <= 1'b0;
            r_busy        <= 1'b0;
            r_load_pend   <= 1'b0;
            r_err_pend    <= 1'b0;
        end else begin
            r_valid       <= r_load_pend;
            r_frame_error <= r_err_pend;
            r_load_pend   <= 1'b0;
            r_err_pend    <= 1'b0;
            if (r_load_pend) begin
                r_d_out <= r_shift;
            end

            case (r_state)
                ST_IDLE: begin
                    r_clk_count <= 24'd0;
                    if (!w_rx_s) begin
                        r_state <= ST_START;
                        r_busy  <= 1'b1;
                    end
                end

                ST_START: begin
                    if (r_clk_count == HALF_TICK) begin
                        r_clk_count <= 24'd0;
                        r_bit_count <= 4'd0;
                        if (!w_rx_s) begin
                            r_state <= ST_DATA;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_clk_count <= r_clk_count + 24'd1;
                    end
                end

                ST_DATA: begin
                    if (r_clk_count == LAST_TICK) begin
                        r_clk_count <= 24'd0;
                        r_shift     <= {w_rx_s, r_shift[7:1]};
                        r_bit_count <= r_bit_count + 4'd1;
                        if (r_bit_count == LAST_BIT) begin
                            r_state <= ST_STOP;
                        end
                    end else begin
                        r_clk_count <= r_clk_count + 24'd1;
                    end
                end

                ST_STOP: begin
                    if (r_clk_count == LAST_TICK) begin
                        r_clk_count <= 24'd0;
                        if (w_rx_s) begin
                            r_load_pend <= 1'b1;
                            r_state     <= ST_IDLE;
                            r_busy      <= 1'b0;
                        end else begin
                            r_err_pend <= 1'b1;
                            r_state    <= ST_BREAK;
                        end
                    end else begin
                        r_clk_count <= r_clk_count + 24'd1;
                    end
                end

                ST_BREAK: begin
                    r_clk_count <= 24'd0;
                    if (w_rx_s) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_clk_count <= 24'd0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign uart_d_out       = r_d_out;
    assign uart_rx_valid    = r_valid;
    assign uart_frame_error = r_frame_error;
    assign uart_rx_busy     = r_busy;
    assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: drives serial frames at chosen bit periods and checks
// decoded bytes, pulse timing and error handling against a frame-level model.
module tb_uart_rx;
    import uart_pkg::*;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           d_in = 1'b1;
    logic [7:0]     d_out;
    logic           rx_valid;
    logic           frame_error;
    logic           rx_busy;
    uart_rx_state_t dbg_state;

    uart_rx dut (
        .uart_clock       (clk),
        .uart_reset       (rst),
        .uart_d_in        (d_in),
        .uart_d_out       (d_out),
        .uart_rx_valid    (rx_valid),
        .uart_frame_error (frame_error),
        .uart_rx_busy     (rx_busy),
        .o_dbg_state      (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks   = 0;
    int failures = 0;

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         got_t[$];
    int         err_t[$];
    logic [7:0] last_good = 8'h00;
    logic       prev_pulse = 1'b0;

    always @(negedge clk) begin
        if (rx_valid) begin
            got_q.push_back(d_out);
            got_t.push_back(cyc);
        end
        if (frame_error) err_t.push_back(cyc);
        if (rx_valid || frame_error) begin
            checks++;
            if ((rx_valid && frame_error) || prev_pulse) begin
                failures++;
                $display("FAIL pulse_exclusive cyc=%0d valid=%0b err=%0b prev_pulse=%0b required single isolated pulse",
                         cyc, rx_valid, frame_error, prev_pulse);
            end
        end
        prev_pulse = rx_valid || frame_error;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_obs();
        got_q.delete();
        got_t.delete();
        err_t.delete();
        exp_q.delete();
    endtask

    // Called at a negedge; returns at the negedge where the stop bit ends.
    task automatic send_frame(input logic [7:0] b, input int period,
                              input logic stop_bit, output int t0);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        t0 = cyc;
        for (int i = 0; i < 10; i++) begin
            d_in = bits[i];
            wait_cycles(period);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        d_in = 1'b1;
        wait_cycles(100);
        checks++;
        if (d_out !== 8'h00) begin failures++; $display("FAIL reset_d_out got=%h exp=00", d_out); end
        checks++;
        if (rx_valid !== 1'b0 || frame_error !== 1'b0) begin
            failures++; $display("FAIL reset_pulses valid=%b err=%b exp=0/0", rx_valid, frame_error);
        end
        checks++;
        if (rx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", rx_busy); end
        checks++;
        if (got_q.size() != 0 || err_t.size() != 0) begin
            failures++; $display("FAIL reset_no_pulses valids=%0d errs=%0d exp=0/0", got_q.size(), err_t.size());
        end
        rst = 1'b0;
        wait_cycles(10);
    endtask

    // Sends one good frame and checks decode, count and (at nominal rate) latency.
    task automatic run_good_frame(input string name, input logic [7:0] b,
                                  input int period, input int gap);
        int t0;
        clear_obs();
        exp_q.push_back(b);
        send_frame(b, period, 1'b1, t0);
        wait_cycles(gap);
        checks++;
        if (got_q.size() != 1) begin
            failures++; $display("FAIL %s_count byte=%h got=%0d exp=1", name, b, got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== exp_q[0]) begin
                failures++; $display("FAIL %s_data got=%h exp=%h", name, got_q[0], exp_q[0]);
            end
            if (period == 50) begin
                checks++;
                if (got_t[0] - t0 < 478 || got_t[0] - t0 > 480) begin
                    failures++; $display("FAIL %s_latency byte=%h got=%0d exp=479+-1", name, b, got_t[0] - t0);
                end
            end
        end
        checks++;
        if (err_t.size() != 0) begin failures++; $display("FAIL %s_err byte=%h errs=%0d exp=0", name, b, err_t.size()); end
        last_good = b;
        checks++;
        if (d_out !== last_good) begin failures++; $display("FAIL %s_hold got=%h exp=%h", name, d_out, last_good); end
    endtask

    task automatic test_known_frames();
        logic [7:0] pat[5];
        pat = '{8'hA5, 8'h00, 8'hFF, 8'h01, 8'h80};
        foreach (pat[i]) run_good_frame("known", pat[i], 50, 5);
    endtask

    task automatic test_random_frames();
        for (int i = 0; i < 8; i++) begin
            run_good_frame("random", 8'($urandom_range(0, 255)),
                           $urandom_range(48, 52), $urandom_range(2, 20));
        end
    endtask

    task automatic test_false_start();
        clear_obs();
        d_in = 1'b0;
        wait_cycles(5);
        checks++;
        if (rx_busy !== 1'b1) begin failures++; $display("FAIL false_start_busy_hi got=%b exp=1", rx_busy); end
        wait_cycles(5);
        d_in = 1'b1;
        wait_cycles(30);
        checks++;
        if (rx_busy !== 1'b0) begin failures++; $display("FAIL false_start_busy_lo got=%b exp=0", rx_busy); end
        checks++;
        if (got_q.size() != 0 || err_t.size() != 0) begin
            failures++; $display("FAIL false_start_pulses valids=%0d errs=%0d exp=0/0", got_q.size(), err_t.size());
        end
        checks++;
        if (d_out !== last_good) begin failures++; $display("FAIL false_start_hold got=%h exp=%h", d_out, last_good); end
    endtask

    task automatic test_frame_error();
        int t0;
        clear_obs();
        send_frame(8'h3C, 50, 1'b0, t0);
        wait_cycles(1000);
        checks++;
        if (err_t.size() != 1) begin failures++; $display("FAIL ferr_count got=%0d exp=1", err_t.size()); end
        checks++;
        if (got_q.size() != 0) begin failures++; $display("FAIL ferr_valid got=%0d exp=0", got_q.size()); end
        checks++;
        if (d_out !== last_good) begin failures++; $display("FAIL ferr_hold got=%h exp=%h", d_out, last_good); end
        checks++;
        if (rx_busy !== 1'b1) begin failures++; $display("FAIL ferr_break_busy got=%b exp=1", rx_busy); end
        d_in = 1'b1;
        wait_cycles(10);
        checks++;
        if (rx_busy !== 1'b0 || err_t.size() != 1) begin
            failures++; $display("FAIL ferr_release busy=%b errs=%0d exp=0/1", rx_busy, err_t.size());
        end
        run_good_frame("after_ferr", 8'h5A, 50, 5);
    endtask

    task automatic test_back_to_back();
        int t0;
        logic [7:0] bytes[3];
        bytes = '{8'h12, 8'h34, 8'h56};
        clear_obs();
        foreach (bytes[i]) begin
            exp_q.push_back(bytes[i]);
            send_frame(bytes[i], 51, 1'b1, t0);
        end
        wait_cycles(10);
        checks++;
        if (got_q.size() != 3) begin
            failures++; $display("FAIL b2b_count got=%0d exp=3", got_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    failures++; $display("FAIL b2b_data idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (err_t.size() != 0) begin failures++; $display("FAIL b2b_err got=%0d exp=0", err_t.size()); end
        last_good = 8'h56;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        clear_obs();
        d_in = 1'b0;
        wait_cycles(50);
        for (int i = 0; i < 3; i++) begin
            d_in = b[i];
            wait_cycles(50);
        end
        d_in = b[3];
        wait_cycles(25);
        rst = 1'b1;
        d_in = 1'b1;
        wait_cycles(1);
        last_good = 8'h00;
        checks++;
        if (d_out !== 8'h00 || rx_valid !== 1'b0 || frame_error !== 1'b0 || rx_busy !== 1'b0) begin
            failures++;
            $display("FAIL midreset_outputs d_out=%h valid=%b err=%b busy=%b exp=00/0/0/0",
                     d_out, rx_valid, frame_error, rx_busy);
        end
        checks++;
        if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL midreset_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
        rst = 1'b0;
        wait_cycles(600);
        checks++;
        if (got_q.size() != 0 || err_t.size() != 0) begin
            failures++; $display("FAIL midreset_pulses valids=%0d errs=%0d exp=0/0", got_q.size(), err_t.size());
        end
        run_good_frame("after_reset", 8'hC3, 50, 5);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_known_frames();
        test_random_frames();
        test_false_start();
        test_frame_error();
        test_back_to_back();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
